// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: serially loads a pattern into a falling-edge scan chain,
// runs one functional capture cycle, then unloads the captured contents.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; chain in functional mode
// S_LOAD    | CHAIN_LEN shift cycles, pattern MSB first on scan_in
// S_CAPTURE | one functional cycle; chain captures its D inputs
// S_UNLOAD  | CHAIN_LEN shift cycles, FILL on scan_in, scan_out sampled
// S_DONE    | one cycle, done pulse, unload_data valid
module scan_chain_ctrl #(
   parameter int unsigned CHAIN_LEN = 16,
   parameter logic        FILL      = 1'b0
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] load_data,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] unload_data,
   output logic                 scan_en,
   output logic                 scan_in,
   input  logic                 scan_out,
   output logic                 capture
);

   localparam int unsigned   CW   = $clog2(CHAIN_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_CAPTURE = 3'd2,
      S_UNLOAD  = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [CW-1:0]        r_cnt;
   logic [CHAIN_LEN-1:0] r_load;
   logic [CHAIN_LEN-1:0] r_unload;
   logic [CHAIN_LEN-1:0] w_unload_next;
   logic                 w_tc;

   assign w_tc        = (r_cnt == LAST);
   assign unload_data = r_unload;

   // The first sample (flop CHAIN_LEN-1) must end up in the MSB after all shifts.
   if (CHAIN_LEN == 1) begin : g_unload_one
      assign w_unload_next = scan_out;
   end else begin : g_unload_many
      assign w_unload_next = {r_unload[CHAIN_LEN-2:0], scan_out};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = S_LOAD;
         S_LOAD:    if (w_tc) w_next = S_CAPTURE;
         S_CAPTURE: w_next = S_UNLOAD;
         S_UNLOAD:  if (w_tc) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt    <= '0;
         r_load   <= '0;
         r_unload <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_load <= load_data;
                  r_cnt  <= '0;
               end
            end
            S_LOAD: begin
               r_load <= r_load << 1;
               r_cnt  <= w_tc ? '0 : r_cnt + CW'(1);
            end
            S_CAPTURE: begin
               r_unload <= w_unload_next;
            end
            S_UNLOAD: begin
               // The final unload shift carries nothing new, so it is not sampled.
               if (!w_tc) r_unload <= w_unload_next;
               r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Pure decode of rising-edge registers, giving the falling-edge chain half a cycle of setup.
   always_comb begin
      busy    = 1'b1;
      done    = 1'b0;
      scan_en = 1'b0;
      scan_in = 1'b0;
      capture = 1'b0;
      case (r_state)
         S_IDLE:    busy = 1'b0;
         S_LOAD: begin
            scan_en = 1'b1;
            scan_in = r_load[CHAIN_LEN-1];
         end
         S_CAPTURE: capture = 1'b1;
         S_UNLOAD: begin
            scan_en = 1'b1;
            scan_in = FILL;
         end
         S_DONE:    done = 1'b1;
         default:   busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: drives a 16-flop and a 1-flop instance, each attached
// to a behavioural falling-edge scan chain, and checks them against a transaction-level model.
module tb_scan_chain_ctrl;

   localparam int   N      = 16;
   localparam logic FILL16 = 1'b0;
   localparam logic FILL1  = 1'b1;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   logic         start16 = 1'b0;
   logic [N-1:0] load16  = '0;
   logic         busy16, done16, scan_en16, scan_in16, scan_out16, capture16;
   logic [N-1:0] unload16;

   logic         start1 = 1'b0;
   logic [0:0]   load1  = '0;
   logic         busy1, done1, scan_en1, scan_in1, scan_out1, capture1;
   logic [0:0]   unload1;

   // chain_mode 0: every flop has D = ~Q; 1: D tied to dvec
   int           chain_mode = 0;
   logic [N-1:0] dvec       = '0;
   logic [N-1:0] chain16    = '0;
   logic         chain1     = 1'b0;

   always @(negedge CLK) begin
      if (scan_en16) chain16 <= {chain16[N-2:0], scan_in16};
      else           chain16 <= (chain_mode == 0) ? ~chain16 : dvec;
      chain1 <= scan_en1 ? scan_in1 : ~chain1;
   end
   assign scan_out16 = chain16[N-1];
   assign scan_out1  = chain1;

   scan_chain_ctrl #(.CHAIN_LEN(N), .FILL(FILL16)) dut16 (
      .CLK(CLK), .RST(RST), .start(start16), .load_data(load16),
      .busy(busy16), .done(done16), .unload_data(unload16),
      .scan_en(scan_en16), .scan_in(scan_in16), .scan_out(scan_out16),
      .capture(capture16)
   );

   scan_chain_ctrl #(.CHAIN_LEN(1), .FILL(FILL1)) dut1 (
      .CLK(CLK), .RST(RST), .start(start1), .load_data(load1),
      .busy(busy1), .done(done1), .unload_data(unload1),
      .scan_en(scan_en1), .scan_in(scan_in1), .scan_out(scan_out1),
      .capture(capture1)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // One full sequence on the 16-flop instance; optionally pokes start in CAPTURE and DONE.
   task automatic seq16(input logic [N-1:0] l, input int mode, input logic [N-1:0] d,
                        input bit poke, input string tag);
      logic [N-1:0] exp_u;
      logic [4:0]   exp_o, got_o;
      exp_u      = (mode == 0) ? ~l : d;
      chain_mode = mode;
      dvec       = d;
      load16     = l;
      start16    = 1'b1;
      step();
      start16 = 1'b0;
      load16  = N'($urandom);
      for (int c = 1; c <= 2*N+2; c++) begin
         if (c <= N)            exp_o = {1'b1, 1'b0, 1'b1, l[N-c], 1'b0};
         else if (c == N+1)     exp_o = 5'b10001;
         else if (c <= 2*N+1)   exp_o = {1'b1, 1'b0, 1'b1, FILL16, 1'b0};
         else                   exp_o = 5'b11000;
         got_o = {busy16, done16, scan_en16, scan_in16, capture16};
         n_checks++;
         if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL %s cycle %0d {busy,done,se,si,cap} got %b want %b", tag, c, got_o, exp_o);
         end
         if (c == 2*N+2) begin
            n_checks++;
            if (unload16 !== exp_u) begin
               n_fail++;
               $display("FAIL %s unload_data got %h want %h", tag, unload16, exp_u);
            end
         end
         start16 = (poke && (c == N+1 || c == 2*N+2)) ? 1'b1 : 1'b0;
         step();
      end
      start16 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         got_o = {busy16, done16, scan_en16, scan_in16, capture16};
         n_checks++;
         if (got_o !== 5'b00000 || unload16 !== exp_u) begin
            n_fail++;
            $display("FAIL %s idle hold %0d outs %b unload %h want 00000 / %h", tag, k, got_o, unload16, exp_u);
         end
         step();
      end
   endtask

   task automatic test_reset();
      RST     = 1'b1;
      start16 = 1'b1;
      start1  = 1'b1;
      step();
      step();
      n_checks++;
      if ({busy16, done16, scan_en16, scan_in16, capture16} !== 5'b0 || unload16 !== '0) begin
         n_fail++;
         $display("FAIL reset16 outs %b unload %h want 0", {busy16, done16, scan_en16, scan_in16, capture16}, unload16);
      end
      n_checks++;
      if ({busy1, done1, scan_en1, scan_in1, capture1} !== 5'b0 || unload1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset1 outs %b unload %b want 0", {busy1, done1, scan_en1, scan_in1, capture1}, unload1);
      end
      RST     = 1'b0;
      start16 = 1'b0;
      start1  = 1'b0;
      step();
      n_checks++;
      if (busy16 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dominates busy16 %b busy1 %b want 0", busy16, busy1);
      end
   endtask

   task automatic test_known_patterns();
      seq16(16'hA5C3, 0, '0, 1'b0, "a5c3");
      n_checks++;
      if (unload16 !== 16'h5A3C) begin
         n_fail++;
         $display("FAIL a5c3_const unload got %h want 5a3c", unload16);
      end
      seq16(16'hFFFF, 1, 16'h0000, 1'b0, "d_zero");
      seq16(16'h0000, 1, 16'hFFFF, 1'b0, "d_ones");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         seq16(N'($urandom), int'($urandom_range(0, 1)), N'($urandom), 1'b1, "random");
      end
   endtask

   // Model: a start seen while idle launches a 2N+2 cycle busy window ending in a done cycle.
   task automatic test_back_to_back();
      int           m_left, n_next, m_dones, d_dones;
      logic [N-1:0] m_lat;
      m_left     = 0;
      m_dones    = 0;
      d_dones    = 0;
      m_lat      = '0;
      chain_mode = 0;
      for (int cyc = 0; cyc < 140; cyc++) begin
         start16 = (cyc < 100);
         load16  = N'($urandom);
         if (m_left == 0 && start16) begin
            m_lat  = load16;
            n_next = 2*N+2;
         end else begin
            n_next = (m_left > 0) ? m_left - 1 : 0;
         end
         step();
         m_left = n_next;
         n_checks++;
         if (busy16 !== (m_left > 0) || done16 !== (m_left == 1)) begin
            n_fail++;
            $display("FAIL b2b cycle %0d busy %b done %b want %b %b", cyc, busy16, done16, m_left > 0, m_left == 1);
         end
         if (m_left == 1) begin
            m_dones++;
            n_checks++;
            if (unload16 !== ~m_lat) begin
               n_fail++;
               $display("FAIL b2b unload got %h want %h", unload16, ~m_lat);
            end
         end
         if (done16 === 1'b1) d_dones++;
      end
      start16 = 1'b0;
      n_checks++;
      if (d_dones != m_dones || m_dones != 3) begin
         n_fail++;
         $display("FAIL b2b done count got %0d want %0d", d_dones, m_dones);
      end
   endtask

   task automatic test_reset_midflight();
      logic [N-1:0] l;
      l          = N'($urandom);
      chain_mode = 0;
      load16     = l;
      start16    = 1'b1;
      step();
      start16 = 1'b0;
      for (int c = 1; c < N+1+5; c++) step();
      n_checks++;
      if (scan_en16 !== 1'b1 || busy16 !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_rst precondition se %b busy %b want 1 1", scan_en16, busy16);
      end
      RST = 1'b1;
      step();
      RST = 1'b0;
      n_checks++;
      if ({busy16, done16, scan_en16, scan_in16, capture16} !== 5'b0 || unload16 !== '0) begin
         n_fail++;
         $display("FAIL mid_rst outs %b unload %h want 0", {busy16, done16, scan_en16, scan_in16, capture16}, unload16);
      end
      for (int k = 0; k < 40; k++) begin
         step();
         n_checks++;
         if (done16 !== 1'b0 || busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst abandoned cycle %0d done %b busy %b want 0 0", k, done16, busy16);
         end
      end
      seq16(N'($urandom), 0, '0, 1'b0, "after_rst");
   endtask

   task automatic test_len1();
      logic [0:0] l;
      logic [4:0] exp_o, got_o;
      for (int i = 0; i < 4; i++) begin
         l      = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom);
         load1  = l;
         start1 = 1'b1;
         step();
         start1 = 1'b0;
         load1  = ~l;
         for (int c = 1; c <= 5; c++) begin
            case (c)
               1:       exp_o = {1'b1, 1'b0, 1'b1, l[0], 1'b0};
               2:       exp_o = 5'b10001;
               3:       exp_o = {1'b1, 1'b0, 1'b1, FILL1, 1'b0};
               4:       exp_o = 5'b11000;
               default: exp_o = 5'b00000;
            endcase
            got_o = {busy1, done1, scan_en1, scan_in1, capture1};
            n_checks++;
            if (got_o !== exp_o) begin
               n_fail++;
               $display("FAIL len1 iter %0d cycle %0d outs got %b want %b", i, c, got_o, exp_o);
            end
            if (c == 4) begin
               n_checks++;
               if (unload1 !== ~l) begin
                  n_fail++;
                  $display("FAIL len1 unload got %b want %b", unload1, ~l);
               end
            end
            step();
         end
      end
   endtask

   initial begin
      test_reset();
      test_known_patterns();
      test_random();
      test_back_to_back();
      test_reset_midflight();
      test_len1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 16: number of scan flops in the driven chain; legal range 1..1024.
REQ-002 SHALL have parameter FILL, default 1'b0: scan_in value driven during unload shifting.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  request one load/capture/unload sequence; sampled only in IDLE.
REQ-006 SHALL have port load_data  input  CHAIN_LEN  pattern to load; sampled on the edge accepting start.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking unload_data valid.
REQ-009 SHALL have port unload_data  output  CHAIN_LEN  captured chain contents.
REQ-010 SHALL have port scan_en  output  1  drives SE of the chain; 1 = shift, 0 = functional capture.
REQ-011 SHALL have port scan_in  output  1  drives SI of chain flop 0.
REQ-012 SHALL have port scan_out  input  1  Q of chain flop CHAIN_LEN-1.
REQ-013 SHALL have port capture  output  1  high exactly during the capture cycle (debug/observe strobe).

Function
REQ-014 SHALL treat the chain as falling-edge flops: flop 0 takes SI, flop k feeds flop k+1; all controller outputs registered off the rising edge (half-cycle setup to the chain).
REQ-015 SHALL implement states IDLE, LOAD, CAPTURE, UNLOAD, DONE.
REQ-016 IDLE: scan_en=0, scan_in=0, capture=0; start=1 -> LOAD, copy load_data to the load shift register, clear the bit counter.
REQ-017 LOAD: exactly CHAIN_LEN cycles, scan_en=1, scan_in = load_data[CHAIN_LEN-1] in the first cycle, descending to load_data[0] in the last; then -> CAPTURE.
REQ-018 CAPTURE: exactly 1 cycle, scan_en=0, capture=1, scan_in=0; then -> UNLOAD.
REQ-019 UNLOAD: exactly CHAIN_LEN cycles, scan_en=1, scan_in=FILL; then -> DONE.
REQ-020 SHALL sample scan_out on the rising edge ending the CAPTURE cycle and on the rising edges ending UNLOAD cycles 1..CHAIN_LEN-1 (CHAIN_LEN samples total); the edge ending the last UNLOAD cycle takes no sample.
REQ-021 Sampling SHALL shift unload_data left by one with scan_out at bit 0, so the first sample (flop CHAIN_LEN-1) ends in bit CHAIN_LEN-1.
REQ-022 DONE: 1 cycle, done=1, scan_en=0; then -> IDLE; total start-accept-to-done latency = 2*CHAIN_LEN+2 cycles.
REQ-023 unload_data SHALL hold its value from DONE until the next LOAD begins.
REQ-024 start while busy=1 SHALL be ignored, not queued; start in DONE cycle ignored.
REQ-025 Bit counter width SHALL be clog2(CHAIN_LEN+1); no wrap before terminal count; CHAIN_LEN=1 gives a 1-cycle LOAD and 1-cycle UNLOAD with the single sample at end of CAPTURE.
REQ-026 X on scan_out SHALL propagate into unload_data unmodified (no masking).

Reset
REQ-027 RST=1 at a rising edge SHALL force IDLE and busy=0, done=0, scan_en=0, scan_in=0, capture=0, unload_data=0, counter=0 on that edge, from any state.
REQ-028 RST SHALL dominate start on the same edge; a sequence interrupted by RST is abandoned and done is not asserted.

Verification
REQ-029 CHAIN_LEN=16, chain model = 16 falling-edge scan flops whose D = ~Q; start with load_data=16'hA5C3 -> scan_in serial 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; done at cycle 34; unload_data=16'h5A3C.
REQ-030 Chain model D tied to 16'h0000, load 16'hFFFF -> unload_data=16'h0000; repeat with D=16'hFFFF, load 16'h0000 -> 16'hFFFF; scan_en low exactly one cycle per sequence.
REQ-031 start held high continuously for 100 cycles -> back-to-back sequences, each 34 cycles, one done pulse each, no start accepted while busy.
REQ-032 RST asserted in UNLOAD cycle 5 -> next cycle all outputs zero, busy=0, no done; new start afterwards completes normally.
REQ-033 CHAIN_LEN=1, D=~Q, load 1'b1 -> scan_in=1 for 1 cycle, capture 1 cycle, unload_data=1'b0, done at cycle 4.
REQ-034 Pulse start during CAPTURE and DONE -> ignored; unload_data stable from DONE until the next LOAD begins.
